// File: rtl/power_arb_pkg.sv
// power_arb_pkg: shared types and constants for the power_arbiter slice.
//   TAG_W(n) : width of a requester ID for n requesters (minimum 1 bit)
//   tag_t    : requester ID as stored in the tag FIFO, sized for the largest
//              legal requester count so one FIFO type serves every build
//   STAT_W   : width of the per-requester grant counters
package power_arb_pkg;

  localparam int STAT_W  = 16;
  localparam int MAX_REQ = 8;

  function automatic int TAG_W(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef logic [TAG_W(MAX_REQ)-1:0] tag_t;

endpackage

// File: rtl/power_arb_tag_fifo.sv
// power_arb_tag_fifo: in-order FIFO of requester IDs for operands in flight.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   push, push_tag    enqueue one requester ID
//   pop, pop_tag      dequeue; pop_tag shows the head entry combinationally
//   full, empty       occupancy flags
//   count             number of stored IDs (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
module power_arb_tag_fifo
  import power_arb_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  tag_t                       push_tag,
  input  logic                       pop,
  output tag_t                       pop_tag,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  tag_t            mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q,  count_d;
  logic            do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign pop_tag = mem_q[rd_ptr_q];

  // A push while full is accepted only when the head leaves in the same cycle.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_tag;
  end

endmodule

// File: rtl/power_arbiter.sv
// power_arbiter: round-robin sharing of one pipelined power unit among
// NUM_REQ requesters, with in-order routing of results back to the issuer.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_data         per-requester operands (requester k at
//                              bits [k*DATA_WIDTH +: DATA_WIDTH])
//   req_ready                  one-hot combinational grant
//   pw_i_valid/pw_i_data       registered issue to the power unit
//   pw_o_valid/pw_o_data       results from the power unit
//   rsp_valid/rsp_data         registered one-hot result strobe and data
//   outstanding                operands in flight
//   tag_err                    sticky: result arrived with no tag pending
//   stat_sel/stat_count        per-requester grant counter readout
// Optional feature macro: POWER_ARB_STATS_EN builds 16-bit saturating grant
// counters; without it stat_count reads 0.
module power_arbiter
  import power_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 64,
  parameter int TAG_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          pw_i_valid,
  output logic [DATA_WIDTH-1:0]         pw_i_data,
  input  logic                          pw_o_valid,
  input  logic [OUT_WIDTH-1:0]          pw_o_data,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [OUT_WIDTH-1:0]          rsp_data,
  output logic [$clog2(TAG_DEPTH):0]    outstanding,
  output logic                          tag_err,
  input  logic [$clog2(NUM_REQ)-1:0]    stat_sel,
  output logic [15:0]                   stat_count
);

  localparam int TW = TAG_W(NUM_REQ);

  logic [TW-1:0]         rr_ptr_q, rr_ptr_d;
  logic                  pw_i_valid_q, pw_i_valid_d;
  logic [DATA_WIDTH-1:0] pw_i_data_q, pw_i_data_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [OUT_WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic                  tag_err_q, tag_err_d;

  logic          grant_any;
  logic [TW-1:0] grant_idx;
  logic          fifo_full, fifo_empty, fifo_pop;
  tag_t          pop_tag;
  logic          unused_pop_tag;

  // Round-robin search starting at rr_ptr. Grants are withheld while the
  // tag FIFO is full (registered count) and while reset is asserted.
  always_comb begin
    int idx;
    idx       = 0;
    req_ready = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    if (!reset && !fifo_full) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        idx = int'(rr_ptr_q) + i;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!grant_any && req_valid[idx]) begin
          grant_any      = 1'b1;
          req_ready[idx] = 1'b1;
          grant_idx      = TW'(idx);
        end
      end
    end
  end

  // Results only pop a tag when one is pending; otherwise they are flagged.
  assign fifo_pop = pw_o_valid & ~fifo_empty;
  assign unused_pop_tag = ^pop_tag;

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    pw_i_valid_d = grant_any;
    pw_i_data_d  = pw_i_data_q;
    rsp_valid_d  = '0;
    rsp_data_d   = rsp_data_q;
    tag_err_d    = tag_err_q | (pw_o_valid & fifo_empty);
    if (grant_any) begin
      rr_ptr_d    = (grant_idx == TW'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
      pw_i_data_d = req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    end
    if (fifo_pop) begin
      rsp_valid_d[pop_tag[TW-1:0]] = 1'b1;
      rsp_data_d                   = pw_o_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q     <= '0;
      pw_i_valid_q <= 1'b0;
      pw_i_data_q  <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      tag_err_q    <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      pw_i_valid_q <= pw_i_valid_d;
      pw_i_data_q  <= pw_i_data_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      tag_err_q    <= tag_err_d;
    end
  end

  power_arb_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (grant_any),
    .push_tag (tag_t'(grant_idx)),
    .pop      (fifo_pop),
    .pop_tag  (pop_tag),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (outstanding)
  );

  assign pw_i_valid = pw_i_valid_q;
  assign pw_i_data  = pw_i_data_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign tag_err    = tag_err_q;

`ifdef POWER_ARB_STATS_EN
  logic [STAT_W-1:0] stat_all [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
    logic [STAT_W-1:0] cnt_q, cnt_d;

    // Saturate at all-ones so a long run never wraps back to a small value.
    always_comb begin
      cnt_d = cnt_q;
      if (req_ready[gi] && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
    end

    assign stat_all[gi] = cnt_q;
  end

  always_comb begin
    stat_count = '0;
    if (int'(stat_sel) < NUM_REQ) stat_count = stat_all[stat_sel];
  end
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^stat_sel;
  assign stat_count      = '0;
`endif

endmodule

// File: tb/tb_power_arbiter.sv
// tb_power_arbiter: directed, table-driven bench for power_arbiter.
// The power unit is modelled as a squaring pipeline of programmable latency.
module tb_power_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int OW = 64;
  localparam int TD = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            pw_i_valid;
  logic [DW-1:0]   pw_i_data;
  logic            pw_o_valid;
  logic [OW-1:0]   pw_o_data;
  logic [NR-1:0]   rsp_valid;
  logic [OW-1:0]   rsp_data;
  logic [3:0]      outstanding;
  logic            tag_err;
  logic [1:0]      stat_sel;
  logic [15:0]     stat_count;

  always #5 clk = ~clk;

  power_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .OUT_WIDTH(OW), .TAG_DEPTH(TD)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .pw_i_valid(pw_i_valid), .pw_i_data(pw_i_data),
    .pw_o_valid(pw_o_valid), .pw_o_data(pw_o_data), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .outstanding(outstanding), .tag_err(tag_err),
    .stat_sel(stat_sel), .stat_count(stat_count)
  );

  // Requester operands 0x2/0x3/0x5/0x7; squared results 4/9/25/49.
  assign req_data = {32'h7, 32'h5, 32'h3, 32'h2};

  function automatic logic [DW-1:0] op_of(input int k);
    case (k)
      0: return 32'h2;
      1: return 32'h3;
      2: return 32'h5;
      default: return 32'h7;
    endcase
  endfunction

  function automatic logic [OW-1:0] res_of(input int k);
    case (k)
      0: return 64'd4;
      1: return 64'd9;
      2: return 64'd25;
      default: return 64'd49;
    endcase
  endfunction

  function automatic int idx_of(input logic [NR-1:0] v);
    int r;
    r = 0;
    for (int i = 0; i < NR; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Power unit model: squaring pipeline, output taken at stage lat-1.
  int          lat = 3;
  logic        inject = 1'b0;
  logic [15:0] st_v;
  logic [DW-1:0] st_d [16];

  always @(posedge clk) begin
    if (reset) st_v <= '0;
    else       st_v <= {st_v[14:0], pw_i_valid};
    st_d[0] <= pw_i_data;
    for (int j = 1; j < 16; j++) st_d[j] <= st_d[j-1];
  end

  always_comb begin
    pw_o_valid = st_v[lat-1] | inject;
    pw_o_data  = '0;
    if (inject)           pw_o_data = 64'hDEAD_BEEF;
    else if (st_v[lat-1]) pw_o_data = 64'(st_d[lat-1]) * 64'(st_d[lat-1]);
  end

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end else begin
      $display("ok   %s: %0h", nm, act);
    end
  endtask

  // Response scoreboard: every strobe must match the oldest expected issuer.
  int mon_k;
  always @(negedge clk) begin
    if (rsp_valid != '0) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL rsp_unexpected: got rsp_valid %b, required none", rsp_valid);
      end else begin
        mon_k = exp_q.pop_front();
        chk("rsp_valid", 64'(rsp_valid), 64'(1 << mon_k));
        chk("rsp_data", rsp_data, res_of(mon_k));
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [NR-1:0] valid;
    logic [NR-1:0] ready;
  } vec_t;
  vec_t tbl [13];

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic drain(input int n);
    req_valid = '0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic          prev_hs;
  logic [DW-1:0] prev_data;
  int            g;

  initial begin
    // Grant table from rr_ptr = 0: {req_valid, expected req_ready}.
    tbl[0]  = '{4'b0000, 4'b0000};
    tbl[1]  = '{4'b0100, 4'b0100};
    tbl[2]  = '{4'b0100, 4'b0100};
    tbl[3]  = '{4'b1111, 4'b1000};
    tbl[4]  = '{4'b1111, 4'b0001};
    tbl[5]  = '{4'b1111, 4'b0010};
    tbl[6]  = '{4'b1111, 4'b0100};
    tbl[7]  = '{4'b0011, 4'b0001};
    tbl[8]  = '{4'b0011, 4'b0010};
    tbl[9]  = '{4'b1001, 4'b1000};
    tbl[10] = '{4'b1001, 4'b0001};
    tbl[11] = '{4'b0000, 4'b0000};
    tbl[12] = '{4'b0101, 4'b0100};

    stat_sel  = 2'd1;
    reset     = 1'b1;
    req_valid = 4'b1111;

    // Reset state, with all requesters asking.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'h0);
    chk("rst_pw_i_valid", 64'(pw_i_valid), 64'h0);
    chk("rst_pw_i_data", 64'(pw_i_data), 64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_rsp_data", rsp_data, 64'h0);
    chk("rst_outstanding", 64'(outstanding), 64'h0);
    chk("rst_tag_err", 64'(tag_err), 64'h0);
    chk("rst_stat_count", 64'(stat_count), 64'h0);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    req_valid = '0;

    // Single requester 2: issue next cycle, response at latency + 2.
    req_valid = 4'b0100;
    @(negedge clk);
    chk("single_ready", 64'(req_ready), 64'b0100);
    exp_q.push_back(2);
    @(posedge clk);
    #1;
    req_valid = '0;
    @(negedge clk);
    chk("single_pw_i_valid", 64'(pw_i_valid), 64'h1);
    chk("single_pw_i_data", 64'(pw_i_data), 64'h5);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("single_rsp_early", 64'(rsp_valid), 64'h0);
    @(posedge clk);
    @(negedge clk);
    chk("single_rsp_onhot", 64'(rsp_valid), 64'b0100);
    chk("single_rsp_data", rsp_data, 64'd25);
    drain(10);

    // Table-driven round-robin sequence from a fresh reset.
    do_reset();
    prev_hs   = 1'b0;
    prev_data = '0;
    for (int i = 0; i < 13; i++) begin
      req_valid = tbl[i].valid;
      @(negedge clk);
      chk($sformatf("vec%0d_ready", i), 64'(req_ready), 64'(tbl[i].ready));
      chk($sformatf("vec%0d_pw_i_valid", i), 64'(pw_i_valid), 64'(prev_hs));
      if (prev_hs) chk($sformatf("vec%0d_pw_i_data", i), 64'(pw_i_data), 64'(prev_data));
      if (tbl[i].ready != '0) begin
        exp_q.push_back(idx_of(tbl[i].ready));
        prev_hs   = 1'b1;
        prev_data = op_of(idx_of(tbl[i].ready));
      end else begin
        prev_hs = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    drain(20);
    chk("table_all_returned", 64'(exp_q.size()), 64'h0);

    // Latency 12 > depth 8: grants in cycles 0..7, stall 8..13, resume at 14.
    lat = 12;
    do_reset();
    req_valid = 4'b1111;
    g = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c < 8 || c >= 14) begin
        chk($sformatf("full_c%0d_ready", c), 64'(req_ready), 64'(1 << (g % 4)));
        exp_q.push_back(g % 4);
        g++;
      end else begin
        chk($sformatf("full_c%0d_ready", c), 64'(req_ready), 64'h0);
        chk($sformatf("full_c%0d_outstanding", c), 64'(outstanding), 64'd8);
      end
      @(posedge clk);
      #1;
    end
    drain(40);
    chk("full_all_returned", 64'(exp_q.size()), 64'h0);

    // Result with nothing outstanding.
    @(negedge clk);
    chk("tagerr_before", 64'(tag_err), 64'h0);
    @(posedge clk);
    #1;
    inject = 1'b1;
    @(posedge clk);
    #1;
    inject = 1'b0;
    @(negedge clk);
    chk("tagerr_set", 64'(tag_err), 64'h1);
    chk("tagerr_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("tagerr_outstanding", 64'(outstanding), 64'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("tagerr_sticky", 64'(tag_err), 64'h1);
    @(posedge clk);
    #1;

    // Reset with three operands in flight.
    req_valid = 4'b0001;
    repeat (3) @(posedge clk);
    #1;
    req_valid = 4'b1111;
    reset     = 1'b1;
    @(negedge clk);
    chk("midrst_outstanding_before", 64'(outstanding), 64'd3);
    chk("midrst_ready_in_reset", 64'(req_ready), 64'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_outstanding", 64'(outstanding), 64'h0);
    chk("midrst_pw_i_valid", 64'(pw_i_valid), 64'h0);
    chk("midrst_pw_i_data", 64'(pw_i_data), 64'h0);
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("midrst_rsp_data", rsp_data, 64'h0);
    chk("midrst_tag_err", 64'(tag_err), 64'h0);
    chk("midrst_ready_req0", 64'(req_ready), 64'b0001);
    exp_q.push_back(0);
    @(posedge clk);
    #1;
    drain(20);
    chk("midrst_all_returned", 64'(exp_q.size()), 64'h0);
    chk("midrst_tag_err_after", 64'(tag_err), 64'h0);

    // Grant statistics.
    lat = 3;
    do_reset();
    req_valid = 4'b0010;
    for (int n = 0; n < 5; n++) begin
      @(posedge clk);
      exp_q.push_back(1);
    end
    #1;
    req_valid = '0;
    stat_sel  = 2'd1;
    @(negedge clk);
`ifdef POWER_ARB_STATS_EN
    chk("stat_req1_5", 64'(stat_count), 64'd5);
`else
    chk("stat_req1_off", 64'(stat_count), 64'd0);
`endif
    stat_sel = 2'd0;
    @(negedge clk);
    chk("stat_req0", 64'(stat_count), 64'd0);
    stat_sel = 2'd1;
    drain(10);
`ifdef POWER_ARB_STATS_EN
    req_valid = 4'b0010;
    for (int n = 0; n < 70000; n++) begin
      @(posedge clk);
      exp_q.push_back(1);
    end
    #1;
    req_valid = '0;
    @(negedge clk);
    chk("stat_req1_sat", 64'(stat_count), 64'hFFFF);
    drain(10);
`endif
    chk("stat_all_returned", 64'(exp_q.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
